// File: rtl/sensor_conditioner_if.sv
// Sensor-side bundle for sensor_conditioner: the four synchronised active-low
// raw inputs and the cleaned event/period outputs handed on to comp_core.
interface sensor_conditioner_if #(
  parameter int unsigned PERIOD_W = 16
);
  logic                nFork;
  logic                nCrank;
  logic                nMode;
  logic                nTrip;
  logic                ForkPulse;
  logic [PERIOD_W-1:0] ForkPeriod;
  logic                ForkValid;
  logic                CrankPulse;
  logic [PERIOD_W-1:0] CrankPeriod;
  logic                CrankValid;
  logic                ModePress;
  logic                ModeLong;
  logic                TripPress;

  modport master (
    output nFork, nCrank, nMode, nTrip,
    input  ForkPulse, ForkPeriod, ForkValid, CrankPulse, CrankPeriod, CrankValid,
    input  ModePress, ModeLong, TripPress
  );

  modport slave (
    input  nFork, nCrank, nMode, nTrip,
    output ForkPulse, ForkPeriod, ForkValid, CrankPulse, CrankPeriod, CrankValid,
    output ModePress, ModeLong, TripPress
  );
endinterface

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: debounces nFork/nCrank/nMode/nTrip, emits one-cycle
// press events and measures wheel/crank periods in clock cycles.
// Optional feature macro: SENSOR_LONG_PRESS_EN (short/long press split on nMode).
module sensor_conditioner #(
  parameter int unsigned DEB_CYCLES  = 160,
  parameter int unsigned PERIOD_W    = 16,
  parameter int unsigned LONG_CYCLES = 32768
) (
  input  logic               Clock,
  input  logic               nReset,
  sensor_conditioner_if.slave bus
);
  localparam int unsigned DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_PRE = {{(PERIOD_W-1){1'b1}}, 1'b0};

  // channel order: 0 fork, 1 crank, 2 mode, 3 trip
  logic [3:0]          raw;
  logic [3:0]          stable;
  logic [3:0]          fall;
  logic [DW-1:0]       deb_cnt [4];
  logic [PERIOD_W-1:0] per_cnt [2];
  logic [PERIOD_W-1:0] period  [2];
  logic [1:0]          valid;
  logic [1:0]          armed;
  logic                fork_pulse;
  logic                crank_pulse;
  logic                trip_press;
  logic                mode_press;
  logic                mode_long;

  assign raw = {bus.nTrip, bus.nMode, bus.nCrank, bus.nFork};

  // Stable value about to fall on this edge (DEB_CYCLES-th differing sample).
  always_comb begin
    fall = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      fall[i] = stable[i] & ~raw[i] & (deb_cnt[i] == DEB_LAST);
    end
  end

  // Debounce: count consecutive samples differing from the accepted level.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      stable <= '1;
      for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (raw[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= raw[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Period measurement for fork and crank. A pulse landing on the saturating
  // edge (cnt == max-1) is treated as a first pulse, so Valid needs cnt < max-1.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      valid <= '0;
      armed <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        per_cnt[i] <= '0;
        period[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (fall[i]) begin
          per_cnt[i] <= PERIOD_W'(1);
          armed[i]   <= 1'b1;
          if (armed[i] && (per_cnt[i] < CNT_PRE)) begin
            period[i] <= per_cnt[i];
            valid[i]  <= 1'b1;
          end else begin
            valid[i]  <= 1'b0;
          end
        end else if (per_cnt[i] != CNT_MAX) begin
          per_cnt[i] <= per_cnt[i] + 1'b1;
          if (per_cnt[i] == CNT_PRE) begin
            valid[i] <= 1'b0;
            armed[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Registered single-cycle press events for fork, crank and trip.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      fork_pulse  <= 1'b0;
      crank_pulse <= 1'b0;
      trip_press  <= 1'b0;
    end else begin
      fork_pulse  <= fall[0];
      crank_pulse <= fall[1];
      trip_press  <= fall[3];
    end
  end

`ifdef SENSOR_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES);

  logic [HW-1:0] hold;
  logic          marked;
  logic          mode_rise;

  assign mode_rise = ~stable[2] & raw[2] & (deb_cnt[2] == DEB_LAST);

  // Hold timer: long press fires once at LONG_CYCLES, short press on release.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      hold       <= '0;
      marked     <= 1'b0;
      mode_press <= 1'b0;
      mode_long  <= 1'b0;
    end else begin
      mode_press <= 1'b0;
      mode_long  <= 1'b0;
      if (fall[2]) begin
        hold   <= HW'(1);
        marked <= 1'b0;
      end else if (mode_rise) begin
        mode_press <= ~marked;
        hold       <= '0;
      end else if (!stable[2] && (hold != HOLD_LAST)) begin
        hold <= hold + 1'b1;
        if (hold + 1'b1 == HOLD_LAST) begin
          mode_long <= 1'b1;
          marked    <= 1'b1;
        end
      end
    end
  end
`else
  // Mode button behaves exactly like the trip button.
  always_ff @(posedge Clock) begin
    if (!nReset) mode_press <= 1'b0;
    else         mode_press <= fall[2];
  end

  assign mode_long = 1'b0;
`endif

  assign bus.ForkPulse   = fork_pulse;
  assign bus.ForkPeriod  = period[0];
  assign bus.ForkValid   = valid[0];
  assign bus.CrankPulse  = crank_pulse;
  assign bus.CrankPeriod = period[1];
  assign bus.CrankValid  = valid[1];
  assign bus.ModePress   = mode_press;
  assign bus.ModeLong    = mode_long;
  assign bus.TripPress   = trip_press;
endmodule
